// File: rtl/tsc_pkg.sv
// tsc_pkg: shared state encoding and default timing constants for the traffic sensor conditioner (see TSC_STUCK_DETECT_EN)
package tsc_pkg;

    typedef enum logic [2:0] {IDLE, QUAL, ACTIVE, HOLD, FAULT} tsc_state_t;

    localparam int DEB_CYCLES_DEF   = 4;
    localparam int HOLD_CYCLES_DEF  = 8;
    localparam int STUCK_CYCLES_DEF = 1024;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tsc_channel.sv
// tsc_channel: one detector channel - 2-flop synchronizer, debounce/hold-off FSM, optional stuck-high fault (TSC_STUCK_DETECT_EN)
module tsc_channel
    import tsc_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic flag,
    output logic fault
);

    localparam int CW = $clog2(max3(DEB_CYCLES, HOLD_CYCLES, STUCK_CYCLES) + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] ONE       = CW'(1);
`ifdef TSC_STUCK_DETECT_EN
    localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYCLES - 1);
`endif

    logic [1:0]    sync;
    logic          s;
    tsc_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;

    assign s       = sync[1];
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // two-flop synchronizer for the asynchronous detector input
    always_ff @(posedge CLK) begin
        if (!RST) sync <= '0;
        else      sync <= {sync[0], raw};
    end

    // state and counter registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // next-state: qualify rising input, hold off falling input
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                state_nxt = s ? QUAL : IDLE;
                cnt_nxt   = s ? ONE : cnt;
            end
            QUAL: begin
                state_nxt = !s ? IDLE : (cnt == DEB_LAST) ? ACTIVE : QUAL;
                cnt_nxt   = (!s || cnt == DEB_LAST) ? '0 : cnt_inc;
            end
            ACTIVE: begin
`ifdef TSC_STUCK_DETECT_EN
                state_nxt = !s ? HOLD : (cnt == STUCK_LAST) ? FAULT : ACTIVE;
                cnt_nxt   = !s ? ONE : (cnt == STUCK_LAST) ? '0 : cnt_inc;
`else
                state_nxt = s ? ACTIVE : HOLD;
                cnt_nxt   = s ? cnt : ONE;
`endif
            end
            HOLD: begin
                state_nxt = s ? ACTIVE : (cnt == HOLD_LAST) ? IDLE : HOLD;
                cnt_nxt   = (s || cnt == HOLD_LAST) ? '0 : cnt_inc;
            end
`ifdef TSC_STUCK_DETECT_EN
            FAULT: begin
                state_nxt = s ? FAULT : IDLE;
                cnt_nxt   = '0;
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // outputs decoded from the state register only
    always_comb begin
        flag = (state == ACTIVE) || (state == HOLD);
`ifdef TSC_STUCK_DETECT_EN
        fault = (state == FAULT);
`else
        fault = 1'b0;
`endif
    end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: two independent conditioned vehicle-detector channels feeding the light controller (TSC_STUCK_DETECT_EN)
module traffic_sensor_conditioner
    import tsc_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic SA_RAW,
    input  logic SB_RAW,
    output logic TA,
    output logic TB,
    output logic FAULT_A,
    output logic FAULT_B
);

    tsc_channel #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_chan_a (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (SA_RAW),
        .flag (TA),
        .fault(FAULT_A)
    );

    tsc_channel #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_chan_b (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (SB_RAW),
        .flag (TB),
        .fault(FAULT_B)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb_traffic_sensor_conditioner: directed self-checking bench, DEB=4 HOLD=8 STUCK=16
module tb_traffic_sensor_conditioner;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic SA_RAW = 1'b0;
    logic SB_RAW = 1'b0;
    logic TA, TB, FAULT_A, FAULT_B;
    int checks = 0;
    int errors = 0;

    traffic_sensor_conditioner #(
        .DEB_CYCLES  (4),
        .HOLD_CYCLES (8),
        .STUCK_CYCLES(16)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SA_RAW (SA_RAW),
        .SB_RAW (SB_RAW),
        .TA     (TA),
        .TB     (TB),
        .FAULT_A(FAULT_A),
        .FAULT_B(FAULT_B)
    );

    always #5 CLK = ~CLK;

    // advance one rising edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        SA_RAW = 1'b0;
        SB_RAW = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            SA_RAW = e[0];
            SB_RAW = ~e[0];
            tick();
            checks++;
            if ({TA, TB, FAULT_A, FAULT_B} !== 4'b0) begin
                errors++;
                $display("FAIL reset_hold edge %0d: outputs=%b required 0000", e, {TA, TB, FAULT_A, FAULT_B});
            end
        end
        RST = 1'b1;
        SA_RAW = 1'b0;
        SB_RAW = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if ({TA, TB, FAULT_A, FAULT_B} !== 4'b0) begin
                errors++;
                $display("FAIL reset_release edge %0d: outputs=%b required 0000", e, {TA, TB, FAULT_A, FAULT_B});
            end
        end
    endtask

    task automatic test_step();
        SA_RAW = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (TA !== (e >= 6) || TB !== 1'b0) begin
                errors++;
                $display("FAIL step_assert edge %0d: TA=%b TB=%b required TA=%b TB=0", e, TA, TB, e >= 6);
            end
        end
    endtask

    task automatic test_hold_cancel();
        SA_RAW = 1'b0;
        repeat (5) begin
            tick();
            checks++;
            if (TA !== 1'b1) begin
                errors++;
                $display("FAIL hold_low TA=%b required 1", TA);
            end
        end
        SA_RAW = 1'b1;
        repeat (12) begin
            tick();
            checks++;
            if (TA !== 1'b1) begin
                errors++;
                $display("FAIL hold_cancel TA=%b required 1", TA);
            end
        end
        SA_RAW = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            checks++;
            if (TA !== (e < 11)) begin
                errors++;
                $display("FAIL release edge %0d: TA=%b required %b", e, TA, e < 11);
            end
        end
    endtask

    task automatic test_bounce();
        logic [13:0] pat;
        idle(4);
        pat = 14'b00000001110111;
        for (int e = 0; e < 14; e++) begin
            SA_RAW = pat[e];
            tick();
            checks++;
            if (TA !== 1'b0) begin
                errors++;
                $display("FAIL bounce edge %0d: TA=%b required 0", e + 1, TA);
            end
        end
    endtask

    task automatic test_simultaneous();
        idle(4);
        SA_RAW = 1'b1;
        SB_RAW = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            checks++;
            if (TA !== (e >= 6) || TB !== (e >= 6)) begin
                errors++;
                $display("FAIL simultaneous edge %0d: TA=%b TB=%b required %b", e, TA, TB, e >= 6);
            end
        end
        RST = 1'b0;
        tick();
        checks++;
        if ({TA, TB, FAULT_A, FAULT_B} !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset: outputs=%b required 0000", {TA, TB, FAULT_A, FAULT_B});
        end
        RST = 1'b1;
        idle(2);
        checks++;
        if ({TA, TB} !== 2'b0) begin
            errors++;
            $display("FAIL post_reset: TA=%b TB=%b required 0 0", TA, TB);
        end
    endtask

    task automatic test_stuck();
        idle(4);
        SB_RAW = 1'b1;
`ifdef TSC_STUCK_DETECT_EN
        for (int e = 1; e <= 24; e++) begin
            tick();
            checks++;
            if (TB !== (e >= 6 && e < 22) || FAULT_B !== (e >= 22) || FAULT_A !== 1'b0) begin
                errors++;
                $display("FAIL stuck edge %0d: TB=%b FAULT_B=%b FAULT_A=%b required %b %b 0", e, TB, FAULT_B, FAULT_A, e >= 6 && e < 22, e >= 22);
            end
        end
        SB_RAW = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if (FAULT_B !== (e < 3) || TB !== 1'b0) begin
                errors++;
                $display("FAIL fault_clear edge %0d: FAULT_B=%b TB=%b required %b 0", e, FAULT_B, TB, e < 3);
            end
        end
`else
        for (int e = 1; e <= 24; e++) begin
            tick();
            checks++;
            if (TB !== (e >= 6) || FAULT_B !== 1'b0 || FAULT_A !== 1'b0) begin
                errors++;
                $display("FAIL no_stuck edge %0d: TB=%b FAULT_B=%b FAULT_A=%b required %b 0 0", e, TB, FAULT_B, FAULT_A, e >= 6);
            end
        end
        SB_RAW = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_step();
        test_hold_cancel();
        test_bounce();
        test_simultaneous();
        test_stuck();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
